mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the operand and HI/LO register width; only 32 SHALL be required to work.
REQ-002 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  32  rs operand; also shared with ALU input A.
- B  in  32  rt operand; also shared with ALU input B.
- whi  in  1  MTHI write strobe.
- wlo  in  1  MTLO write strobe.
- wd  in  32  write data for MTHI/MTLO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- hi  out  32  HI register, for MFHI.
- lo  out  32  LO register, for MFLO.

Function
REQ-003 The block SHALL use three states: IDLE, RUN and FIX.
REQ-004 In IDLE, start=1 at a rising edge SHALL latch A, B and op, load the iteration counter with 31, and enter RUN.
REQ-005 In RUN, the block SHALL perform one iteration per cycle.
- When the counter is 0 at an edge, the block SHALL enter FIX; otherwise it SHALL decrement the counter.
- MULT/MULTU SHALL use radix-2 shift-add on magnitudes.
- DIV/DIVU SHALL use radix-2 restoring division on magnitudes.
REQ-006 In FIX, the block SHALL apply sign correction, write the result into {hi,lo} at the exiting edge, and return to IDLE.
REQ-007 done SHALL be 1 for exactly the cycle following the FIX exit edge, and SHALL be 0 at all other times.
REQ-008 busy SHALL be 1 exactly while the state is RUN or FIX.
REQ-009 Latency: with start accepted at edge N, hi/lo SHALL update and done SHALL rise at edge N+33.
REQ-010 Multiply results SHALL be written as {hi,lo} = the full 64-bit product.
- MULT SHALL treat A and B as two's complement.
- MULTU SHALL treat A and B as unsigned.
REQ-011 Divide results SHALL be written as lo = quotient and hi = remainder.
- DIV SHALL truncate toward zero.
- The DIV remainder SHALL take the sign of A.
- DIVU SHALL be unsigned.
REQ-012 Divide by zero (B=0) SHALL NOT trap, and SHALL write hi=A, lo=32'hFFFFFFFF for both DIV and DIVU.
REQ-013 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL write lo=32'h80000000, hi=0.
REQ-014 start SHALL be ignored while busy=1; the in-flight operation SHALL be unaffected.
REQ-015 start asserted in the cycle done=1 SHALL be accepted, since the state is IDLE.
REQ-016 When busy=0, whi/wlo SHALL load wd into hi/lo at the rising edge; both MAY be asserted together.
REQ-017 whi/wlo SHALL be ignored while busy=1.
REQ-018 If whi/wlo and start are asserted in the same IDLE cycle, the write SHALL occur and the operation SHALL also start; the result SHALL later overwrite hi/lo.
REQ-019 hi/lo SHALL change only at a FIX exit edge, on an accepted whi/wlo write, or on reset.
REQ-020 All iteration arithmetic SHALL be carried in 64-bit or 33-bit internal registers with no truncation before the FIX stage.

Reset
REQ-021 reset=1 SHALL asynchronously force the state to IDLE, the counter to 0, busy=0, done=0, hi=0 and lo=0.
REQ-022 Reset asserted during RUN or FIX SHALL abort the operation without writing a result.
REQ-023 After reset is released, the first rising edge SHALL sample start normally.
REQ-024 Internal operand and accumulator registers SHALL clear to 0 on reset.

Verification
REQ-025 The bench SHALL cover MULT A=32'hFFFFFFFE (-2), B=3: done at edge N+33 with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; busy high for exactly 33 cycles.
REQ-026 The bench SHALL cover MULTU A=B=32'hFFFFFFFF: hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-027 The bench SHALL cover DIV A=-7, B=2: lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). It SHALL also cover DIVU A=7, B=0: hi=7, lo=32'hFFFFFFFF.
REQ-028 The bench SHALL cover DIV A=32'h80000000, B=32'hFFFFFFFF: lo=32'h80000000, hi=0, with no X on any output.
REQ-029 The bench SHALL cover a second start and a whi pulse with wd=32'h1234 issued mid-RUN: both ignored, and the first result delivered unchanged. start issued in the done cycle SHALL launch the next operation.
REQ-030 The bench SHALL cover reset asserted at cycle 10 of RUN: immediately busy=0, done=0, hi=lo=0, and no done pulse afterwards. A subsequent MULTU 5x6 SHALL give lo=30, hi=0.

Source files
------------

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies use radix-2 shift-add and divides use radix-2 restoring division,
// both on operand magnitudes; signs are restored in a single FIX cycle.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             whi,
  input  logic             wlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic             is_div_r;
  logic             neg_a_r, neg_b_r, bz_r;
  logic [WIDTH-1:0] a_r;        // raw A, returned as HI on divide by zero
  logic [2*WIDTH-1:0] mcand_r;  // shifted multiplicand
  logic [2*WIDTH-1:0] prod_r;   // product accumulator
  logic [WIDTH-1:0] sh_r;       // multiplier (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] dvs_r;      // divisor magnitude
  logic [WIDTH-1:0] rem_r;      // partial remainder
  logic             busy_r, done_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  // operand magnitudes at launch; ops 00 and 10 are the signed ones
  logic             signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  // iteration step values
  logic [WIDTH:0]   shifted_s, diff_s;
  logic             ge_s;
  // sign-corrected results
  logic             neg_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s, res_hi_s, res_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Launch-time sign extraction and magnitude conversion
  always_comb begin
    signed_s = ~op[0];
    a_neg_s  = signed_s & A[WIDTH-1];
    b_neg_s  = signed_s & B[WIDTH-1];
    if (a_neg_s) a_mag_s = -A;
    else         a_mag_s = A;
    if (b_neg_s) b_mag_s = -B;
    else         b_mag_s = B;
  end

  // One restoring-division step: shift in next dividend bit, trial subtract
  always_comb begin
    shifted_s = {rem_r, sh_r[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, dvs_r});
    if (ge_s) diff_s = shifted_s - {1'b0, dvs_r};
    else      diff_s = shifted_s;
  end

  // Sign correction and result selection used at the FIX exit edge
  always_comb begin
    neg_s = neg_a_r ^ neg_b_r;
    if (neg_s) begin
      prod_fix_s = -prod_r;
      q_fix_s    = -sh_r;
    end else begin
      prod_fix_s = prod_r;
      q_fix_s    = sh_r;
    end
    if (neg_a_r) r_fix_s = -rem_r;
    else         r_fix_s = rem_r;
    if (!is_div_r) begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end else if (bz_r) begin
      res_hi_s = a_r;
      res_lo_s = '1;
    end else begin
      res_hi_s = r_fix_s;
      res_lo_s = q_fix_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == '0) state_s = FIX;
        else             state_s = RUN;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered busy/done flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_r == FIX);
    end
  end

  // Operand latch at launch and one arithmetic iteration per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      is_div_r <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      bz_r     <= 1'b0;
      a_r      <= '0;
      mcand_r  <= '0;
      prod_r   <= '0;
      sh_r     <= '0;
      dvs_r    <= '0;
      rem_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= CNT_LAST;
            is_div_r <= op[1];
            neg_a_r  <= a_neg_s;
            neg_b_r  <= b_neg_s;
            bz_r     <= (B == '0);
            a_r      <= A;
            mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
            prod_r   <= '0;
            sh_r     <= op[1] ? a_mag_s : b_mag_s;
            dvs_r    <= b_mag_s;
            rem_r    <= '0;
          end
        end
        RUN: begin
          if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
          if (is_div_r) begin
            rem_r <= diff_s[WIDTH-1:0];
            sh_r  <= {sh_r[WIDTH-2:0], ge_s};
          end else begin
            if (sh_r[0]) prod_r <= prod_r + mcand_r;
            mcand_r <= mcand_r << 1;
            sh_r    <= sh_r >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result write on FIX exit, MTHI/MTLO only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state_r == FIX) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if (state_r == IDLE) begin
      if (whi) hi_r <= wd;
      if (wlo) lo_r <= wd;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed and random checks of the mdu multiply/divide unit with a result scoreboard.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start, whi, wlo;
  logic [1:0]  op;
  logic [31:0] A, B, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int n_start = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'h0;

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .whi(whi), .wlo(wlo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // count rising edges to measure latency
  always @(posedge clk) edges <= edges + 1;

  // reference result using native SystemVerilog arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    case (o)
      2'b00: model = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'b01: model = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) model = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = {32'h0, 32'h80000000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          model = {r, q};
        end
      end
      default: begin
        if (b == 32'h0) model = {a, 32'hFFFFFFFF};
        else model = {a % b, a / b};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge: present an operation for the next rising edge
  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    exp_q.push_back(model(o, a, b));
    n_start = edges + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // wait (bounded) for done, then check latency, busy length and result
  task automatic wait_done(input string tag, input int exp_bc);
    int k = 0;
    int bc = 0;
    logic [63:0] e;
    if (busy === 1'b1) bc++;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      if (busy === 1'b1) bc++;
    end
    chk({tag, "_done"}, {63'h0, done}, 64'h1);
    chk({tag, "_lat"}, 64'(edges - n_start), 64'd33);
    chk({tag, "_busy"}, 64'(bc), 64'(exp_bc));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 64'hx;
    chk({tag, "_res"}, {hi, lo}, e);
    last_res = e;
  endtask

  initial begin
    int dc;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'h0; B = 32'h0;
    whi = 1'b0; wlo = 1'b0; wd = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_state", {30'h0, busy, done, hi, lo}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -2 * 3, then done is a single-cycle pulse
    go(2'b00, 32'hFFFFFFFE, 32'h3);
    wait_done("mult_neg", 33);
    chk("mult_neg_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    @(negedge clk);
    chk("done_pulse", {62'h0, busy, done}, 64'h0);
    chk("hold_after", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    // MULTU max * max
    go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 33);
    chk("multu_max_val", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(negedge clk);

    // DIV -7/2, with DIVU 7/0 launched in the done cycle
    go(2'b10, 32'hFFFFFFF9, 32'h2);
    wait_done("div_neg", 33);
    chk("div_neg_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    go(2'b11, 32'h7, 32'h0);
    wait_done("divu_z", 33);
    chk("divu_z_val", {hi, lo}, 64'h00000007_FFFFFFFF);
    @(negedge clk);

    // DIV overflow case
    go(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 33);
    chk("div_ovf_val", {hi, lo}, 64'h00000000_80000000);
    chk("div_ovf_x", {63'h0, $isunknown({busy, done, hi, lo})}, 64'h0);
    @(negedge clk);

    // random operations across all four ops, last DIV by zero
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 7) ? 32'h0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 1000));
      go(2'(i % 4), ra, rb);
      wait_done("rand", 33);
      @(negedge clk);
    end

    // MTHI/MTLO while idle
    whi = 1'b1; wlo = 1'b1; wd = 32'hA5A5_0001;
    @(negedge clk);
    whi = 1'b0; wlo = 1'b0;
    chk("mthilo", {hi, lo}, 64'hA5A50001_A5A50001);
    wlo = 1'b1; wd = 32'h0000_0BEE;
    @(negedge clk);
    wlo = 1'b0;
    chk("mtlo_only", {hi, lo}, 64'hA5A50001_00000BEE);

    // MTHI together with start: write happens, result overwrites later
    whi = 1'b1; wd = 32'h0000_CAFE;
    go(2'b01, 32'h5, 32'h7);
    whi = 1'b0;
    chk("mthi_start", {32'h0, hi}, 64'h0000CAFE);
    wait_done("mthi_start", 33);
    chk("mthi_start_val", {hi, lo}, 64'h00000000_00000023);
    @(negedge clk);

    // second start and MTHI mid-RUN are ignored
    go(2'b01, 32'h01234567, 32'h00089ABC);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b10; A = 32'h64; B = 32'h3; whi = 1'b1; wd = 32'h1234;
    @(negedge clk);
    start = 1'b0; whi = 1'b0;
    chk("midrun_hi", {32'h0, hi}, {32'h0, last_res[63:32]});
    wait_done("midrun", 27);
    @(negedge clk);
    chk("midrun_idle", {62'h0, busy, done}, 64'h0);

    // reset during RUN aborts the operation
    go(2'b00, 32'h12345678, 32'h9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_out", {30'h0, busy, done, hi, lo}, 64'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    chk("abort_nodone", 64'(dc), 64'h0);
    go(2'b01, 32'h5, 32'h6);
    wait_done("post_rst", 33);
    chk("post_rst_val", {hi, lo}, 64'h00000000_0000001E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
